// File: rtl/key_scan_seq.sv
// key_scan_seq: debounced piano-key scanner.
// Each key keeps {pressed, cnt} in external RAM through a single-outstanding
// memory-controller handshake. After reset the key bytes are cleared. Each
// scan pass then does a read/update/write for every key, and it emits a
// note-on or note-off event when a key's state flips.
module key_scan_seq #(
  parameter int         NUM_KEYS  = 16,
  parameter int         DEBOUNCE  = 3,
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_vec,
  input  logic                scan_go,
  output logic                busy,
  output logic                mc_start,
  output logic                mc_rw,
  output logic [7:0]          mc_addr,
  output logic [7:0]          mc_wdata,
  input  logic [7:0]          mc_rdata,
  input  logic                mc_done,
  output logic                ev_valid,
  output logic                ev_on,
  output logic [7:0]          ev_key,
  input  logic                ev_ready
);

  localparam logic [7:0] LAST_K = 8'(NUM_KEYS - 1);
  localparam logic [3:0] DEB    = 4'(DEBOUNCE);

  typedef enum logic [3:0] {
    INIT_REQ, INIT_WAIT, IDLE, RD_REQ, RD_WAIT, UPD, WR_REQ, WR_WAIT, EVT, NEXT
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          k_q, k_d;
  logic [NUM_KEYS-1:0] snap_q, snap_d;
  logic [3:0]          data_q, data_d;   // {cnt, pressed} of the current key
  logic                evt_q, evt_d;
  logic                busy_q, busy_d;
  logic                mc_start_q, mc_start_d;
  logic                mc_rw_q, mc_rw_d;
  logic [7:0]          mc_addr_q, mc_addr_d;
  logic [7:0]          mc_wdata_q, mc_wdata_d;
  logic                ev_valid_q, ev_valid_d;
  logic                ev_on_q, ev_on_d;
  logic [7:0]          ev_key_q, ev_key_d;

  // Upper RAM bits carry no state; they are always written back as zero.
  logic rdata_unused;
  assign rdata_unused = ^mc_rdata[7:4];

  // Zero-extended snapshot so any 8-bit key index is a legal bit select.
  logic [255:0] snap_pad;
  assign snap_pad = 256'(snap_q);

  logic [2:0] cnt_rd;
  logic       prs_rd, raw;
  logic [3:0] upd_data;
  logic       upd_evt;

  // Debounce update of the key just read; out-of-range counts saturate.
  always_comb begin
    cnt_rd   = data_q[3:1];
    prs_rd   = data_q[0];
    raw      = snap_pad[k_q];
    upd_evt  = 1'b0;
    upd_data = {3'd0, prs_rd};
    if ({1'b0, cnt_rd} >= DEB) cnt_rd = 3'(DEBOUNCE - 1);
    if (raw == prs_rd) begin
      upd_data = {3'd0, prs_rd};
    end else if ({1'b0, cnt_rd} + 4'd1 == DEB) begin
      upd_data = {3'd0, raw};
      upd_evt  = 1'b1;
    end else begin
      upd_data = {cnt_rd + 3'd1, prs_rd};
    end
  end

  // Next-state and registered-output logic; mc_start is high for the single
  // cycle after each *_REQ state, and the bus fields hold until the next request.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    snap_d     = snap_q;
    data_d     = data_q;
    evt_d      = evt_q;
    busy_d     = busy_q;
    mc_start_d = 1'b0;
    mc_rw_d    = mc_rw_q;
    mc_addr_d  = mc_addr_q;
    mc_wdata_d = mc_wdata_q;
    ev_valid_d = ev_valid_q;
    ev_on_d    = ev_on_q;
    ev_key_d   = ev_key_q;
    case (state_q)
      INIT_REQ: begin
        mc_start_d = 1'b1;
        mc_rw_d    = 1'b1;
        mc_addr_d  = BASE_ADDR + k_q;
        mc_wdata_d = 8'h00;
        state_d    = INIT_WAIT;
      end
      INIT_WAIT: if (mc_done) begin
        if (k_q == LAST_K) begin
          k_d     = 8'd0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = INIT_REQ;
        end
      end
      IDLE: if (scan_go) begin
        snap_d  = key_vec;
        k_d     = 8'd0;
        busy_d  = 1'b1;
        state_d = RD_REQ;
      end
      RD_REQ: begin
        mc_start_d = 1'b1;
        mc_rw_d    = 1'b0;
        mc_addr_d  = BASE_ADDR + k_q;
        state_d    = RD_WAIT;
      end
      RD_WAIT: if (mc_done) begin
        data_d  = mc_rdata[3:0];
        state_d = UPD;
      end
      UPD: begin
        data_d  = upd_data;
        evt_d   = upd_evt;
        state_d = WR_REQ;
      end
      WR_REQ: begin
        mc_start_d = 1'b1;
        mc_rw_d    = 1'b1;
        mc_addr_d  = BASE_ADDR + k_q;
        mc_wdata_d = {4'h0, data_q};
        state_d    = WR_WAIT;
      end
      WR_WAIT: if (mc_done) begin
        if (evt_q) begin
          ev_valid_d = 1'b1;
          ev_key_d   = k_q;
          ev_on_d    = data_q[0];
          state_d    = EVT;
        end else begin
          state_d = NEXT;
        end
      end
      EVT: if (ev_ready) begin
        ev_valid_d = 1'b0;
        state_d    = NEXT;
      end
      NEXT: begin
        if (k_q == LAST_K) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = RD_REQ;
        end
      end
      default: state_d = INIT_REQ;
    endcase
  end

  // State and output registers; reset lands in INIT_REQ with busy set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT_REQ;
      k_q        <= 8'd0;
      snap_q     <= '0;
      data_q     <= 4'd0;
      evt_q      <= 1'b0;
      busy_q     <= 1'b1;
      mc_start_q <= 1'b0;
      mc_rw_q    <= 1'b0;
      mc_addr_q  <= 8'd0;
      mc_wdata_q <= 8'd0;
      ev_valid_q <= 1'b0;
      ev_on_q    <= 1'b0;
      ev_key_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      snap_q     <= snap_d;
      data_q     <= data_d;
      evt_q      <= evt_d;
      busy_q     <= busy_d;
      mc_start_q <= mc_start_d;
      mc_rw_q    <= mc_rw_d;
      mc_addr_q  <= mc_addr_d;
      mc_wdata_q <= mc_wdata_d;
      ev_valid_q <= ev_valid_d;
      ev_on_q    <= ev_on_d;
      ev_key_q   <= ev_key_d;
    end
  end

  assign busy     = busy_q;
  assign mc_start = mc_start_q;
  assign mc_rw    = mc_rw_q;
  assign mc_addr  = mc_addr_q;
  assign mc_wdata = mc_wdata_q;
  assign ev_valid = ev_valid_q;
  assign ev_on    = ev_on_q;
  assign ev_key   = ev_key_q;

endmodule

// File: tb/tb_key_scan_seq.sv
// Bench for key_scan_seq (4 keys, debounce 3): a RAM/controller model
// with random latency, plus scoreboards for expected writes and events.
module tb_key_scan_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_vec = 4'd0;
  logic       scan_go = 1'b0;
  logic       busy, mc_start, mc_rw, ev_valid, ev_on;
  logic [7:0] mc_addr, mc_wdata, ev_key;
  logic [7:0] mc_rdata = 8'd0;
  logic       mc_done = 1'b0;
  logic       ev_ready = 1'b1;

  key_scan_seq #(.NUM_KEYS(4), .DEBOUNCE(3), .BASE_ADDR(8'h00)) dut (
    .clk(clk), .reset(reset), .key_vec(key_vec), .scan_go(scan_go), .busy(busy),
    .mc_start(mc_start), .mc_rw(mc_rw), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_rdata(mc_rdata), .mc_done(mc_done), .ev_valid(ev_valid), .ev_on(ev_on),
    .ev_key(ev_key), .ev_ready(ev_ready));

  always #5 clk = ~clk;

  typedef struct {logic [7:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic [7:0] k; logic on;} ev_t;
  wr_t exp_w[$];
  ev_t exp_ev[$];

  int errors = 0;
  int checks = 0;
  logic [7:0] ram [256];
  logic       pending = 1'b0;
  logic       p_rw;
  logic [7:0] p_addr, p_wd;
  int         lat;
  int         nstart = 0;
  int         pass_ev = 0;
  int         vw = 0;
  int         last_w = 0;
  logic       m_p [4];
  logic [2:0] m_c [4];

  // Memory controller model: one transaction at a time, done 1..3 cycles after start.
  initial begin
    forever begin
      @(posedge clk); #1;
      mc_done = 1'b0;
      if (!reset) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (lat > 1) lat--;
          else begin
            checks++;
            if (mc_addr !== p_addr || mc_rw !== p_rw || mc_wdata !== p_wd)
              begin errors++; $display("FAIL mc_hold: got rw=%0b a=%h d=%h want rw=%0b a=%h d=%h", mc_rw, mc_addr, mc_wdata, p_rw, p_addr, p_wd); end
            if (p_rw) begin
              wr_t e;
              ram[p_addr] = p_wd;
              checks++;
              if (exp_w.size() == 0) begin errors++; $display("FAIL wr_unexpected: got a=%h d=%h want none", p_addr, p_wd); end
              else begin
                e = exp_w.pop_front();
                if (e.a !== p_addr || e.d !== p_wd) begin errors++; $display("FAIL wr_data: got a=%h d=%h want a=%h d=%h", p_addr, p_wd, e.a, e.d); end
              end
            end else begin
              mc_rdata = ram[p_addr];
            end
            mc_done = 1'b1;
            pending = 1'b0;
          end
        end
        if (mc_start) begin
          nstart++;
          checks++;
          if (pending) begin errors++; $display("FAIL mc_overlap: got start while outstanding want none"); end
          pending = 1'b1; p_rw = mc_rw; p_addr = mc_addr; p_wd = mc_wdata;
          lat = $urandom_range(1, 3);
        end
      end
    end
  end

  // Event monitor: pop the expected event at each accepted handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) vw = 0;
      else begin
        if (ev_valid) vw++;
        if (ev_valid && ev_ready) begin
          ev_t e;
          checks++;
          pass_ev++;
          last_w = vw;
          vw = 0;
          if (exp_ev.size() == 0) begin errors++; $display("FAIL ev_unexpected: got key=%0d on=%0b want none", ev_key, ev_on); end
          else begin
            e = exp_ev.pop_front();
            if (ev_key !== e.k || ev_on !== e.on) begin errors++; $display("FAIL ev_data: got key=%0d on=%0b want key=%0d on=%0b", ev_key, ev_on, e.k, e.on); end
          end
        end
      end
    end
  end

  task automatic push_init();
    for (int k = 0; k < 4; k++) begin
      exp_w.push_back('{a: 8'(k), d: 8'h00});
      m_p[k] = 1'b0; m_c[k] = 3'd0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 3000) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_timeout: got busy=%0b want 0", nm, busy); end
  endtask

  task automatic check_out_reset(input string nm);
    checks++;
    if ({busy, mc_start, mc_rw, mc_addr, mc_wdata, ev_valid, ev_on, ev_key} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00})
      begin errors++; $display("FAIL %s: got busy=%0b st=%0b rw=%0b a=%h d=%h v=%0b on=%0b k=%0d want 1 0 0 00 00 0 0 0", nm, busy, mc_start, mc_rw, mc_addr, mc_wdata, ev_valid, ev_on, ev_key); end
  endtask

  // One scan pass: model pushes expectations, then drive scan_go and wait for idle.
  task automatic run_pass(input logic [3:0] kv, input bit scramble, input bit stall, input string nm);
    int exp_n = 0;
    int n = 0;
    bit stalled = 0;
    for (int k = 0; k < 4; k++) begin
      logic [2:0] c;
      c = (m_c[k] >= 3'd3) ? 3'd2 : m_c[k];
      if (kv[k] == m_p[k]) c = 3'd0;
      else if (c == 3'd2) begin
        m_p[k] = kv[k]; c = 3'd0;
        exp_ev.push_back('{k: 8'(k), on: kv[k]});
        exp_n++;
      end else c = c + 3'd1;
      m_c[k] = c;
      exp_w.push_back('{a: 8'(k), d: {4'h0, c, m_p[k]}});
    end
    pass_ev = 0;
    if (stall) ev_ready = 1'b0;
    key_vec = kv; scan_go = 1'b1;
    @(posedge clk); #1;
    scan_go = 1'b0;
    if (scramble) key_vec = ~kv;
    while (busy && n < 3000) begin
      if (stall && !stalled && ev_valid) begin
        logic [7:0] k0;
        int s0;
        k0 = ev_key; s0 = nstart;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          checks++;
          if (ev_valid !== 1'b1 || ev_key !== k0) begin errors++; $display("FAIL %s_stall_hold: got v=%0b k=%0d want 1 %0d", nm, ev_valid, ev_key, k0); end
        end
        checks++;
        if (nstart !== s0) begin errors++; $display("FAIL %s_stall_start: got %0d starts want %0d", nm, nstart, s0); end
        ev_ready = 1'b1; stalled = 1;
      end
      if (scramble) key_vec = 4'($urandom);
      @(posedge clk); #1; n++;
    end
    ev_ready = 1'b1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_timeout: got busy=%0b want 0", nm, busy); end
    checks++;
    if (pass_ev !== exp_n) begin errors++; $display("FAIL %s_ev_count: got %0d want %0d", nm, pass_ev, exp_n); end
    checks++;
    if (exp_w.size() != 0 || exp_ev.size() != 0) begin errors++; $display("FAIL %s_leftover: got w=%0d ev=%0d want 0 0", nm, exp_w.size(), exp_ev.size()); end
    if (stall) begin
      checks++;
      if (!stalled) begin errors++; $display("FAIL %s_stall_seen: got 0 want 1", nm); end
    end
  endtask

  task automatic test_reset();
    int s0;
    for (int i = 0; i < 256; i++) ram[i] = 8'hF7;
    #2 reset = 1'b0;
    #3 check_out_reset("reset_values");
    push_init();
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 scan_go = 1'b1;
    @(posedge clk); #1 scan_go = 1'b0;
    wait_idle("init");
    checks++;
    if (exp_w.size() != 0) begin errors++; $display("FAIL init_writes: got %0d left want 0", exp_w.size()); end
    s0 = nstart;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || nstart !== s0) begin errors++; $display("FAIL init_scan_go_ignored: got busy=%0b starts=%0d want 0 %0d", busy, nstart, s0); end
    checks++;
    if (ram[3] !== 8'h00) begin errors++; $display("FAIL init_ram3: got %h want 00", ram[3]); end
  endtask

  task automatic test_debounce();
    logic [7:0] want [3];
    want[0] = 8'h02; want[1] = 8'h04; want[2] = 8'h01;
    for (int p = 0; p < 3; p++) begin
      run_pass(4'b0100, 0, 0, "debounce");
      checks++;
      if (ram[2] !== want[p]) begin errors++; $display("FAIL debounce_ram2_pass%0d: got %h want %h", p + 1, ram[2], want[p]); end
    end
    checks++;
    if (last_w !== 1) begin errors++; $display("FAIL debounce_one_cycle_ev: got width %0d want 1", last_w); end
  endtask

  task automatic test_release();
    run_pass(4'b0110, 0, 0, "release");
    run_pass(4'b0110, 0, 0, "release");
    checks++;
    if (ram[1] !== 8'h04) begin errors++; $display("FAIL release_ram1_mid: got %h want 04", ram[1]); end
    run_pass(4'b0100, 0, 0, "release");
    checks++;
    if (ram[1] !== 8'h00) begin errors++; $display("FAIL release_ram1: got %h want 00", ram[1]); end
  endtask

  task automatic test_stall();
    run_pass(4'b0000, 0, 0, "stall");
    run_pass(4'b0000, 0, 0, "stall");
    run_pass(4'b0000, 0, 1, "stall");
    checks++;
    if (ram[2] !== 8'h00) begin errors++; $display("FAIL stall_ram2: got %h want 00", ram[2]); end
  endtask

  task automatic test_upper_bits();
    ram[3] = 8'hFE;               // cnt=7 saturates to 2, so one disagreeing scan flips it
    ram[0] = 8'hF0;
    m_c[3] = 3'd2; m_p[3] = 1'b0;
    run_pass(4'b1000, 0, 0, "upper");
    checks++;
    if (ram[3] !== 8'h01 || ram[0] !== 8'h00) begin errors++; $display("FAIL upper_ram: got %h %h want 01 00", ram[3], ram[0]); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    key_vec = 4'b0001; scan_go = 1'b1;
    @(posedge clk); #1 scan_go = 1'b0;
    while (!(pending && !p_rw) && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (!(pending && !p_rw)) begin errors++; $display("FAIL rstmid_no_read: got pending=%0b want 1", pending); end
    #1 reset = 1'b0;
    exp_w.delete(); exp_ev.delete();
    #1 check_out_reset("rstmid_values");
    push_init();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wait_idle("rstmid");
    checks++;
    if (exp_w.size() != 0 || ram[0] !== 8'h00) begin errors++; $display("FAIL rstmid_init: got left=%0d ram0=%h want 0 00", exp_w.size(), ram[0]); end
  endtask

  task automatic test_snapshot();
    for (int p = 0; p < 3; p++) run_pass(4'b1111, 1, 0, "snapshot");
    checks++;
    if (ram[0] !== 8'h01 || ram[3] !== 8'h01) begin errors++; $display("FAIL snapshot_ram: got %h %h want 01 01", ram[0], ram[3]); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_release();
    test_stall();
    test_upper_bits();
    test_reset_mid();
    test_snapshot();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a wait above is ever unbounded.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got still running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/key_scan_seq.md
KEY_SCAN_SEQ -- requirements
Module: key_scan_seq

Interface
REQ-001 Parameter NUM_KEYS, default 16, number of piano keys scanned; legal range 1..256.
REQ-002 Parameter DEBOUNCE, default 3, consecutive disagreeing scans needed to flip a key state; legal range 1..7.
REQ-003 Parameter BASE_ADDR, default 8'h00, RAM address of key 0; key k lives at BASE_ADDR+k, computed modulo 256.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 key_vec  input  NUM_KEYS  raw per-key sensor bits (1 = pressed).
REQ-007 scan_go  input  1  one-cycle request to start a scan pass.
REQ-008 busy  output  1  high from reset release until idle, and during any scan pass.
REQ-009 mc_start  output  1  one-cycle start pulse to the memory controller.
REQ-010 mc_rw  output  1  1 = write, 0 = read; valid with mc_start.
REQ-011 mc_addr  output  8  RAM address for the current transaction.
REQ-012 mc_wdata  output  8  write data for the current transaction.
REQ-013 mc_rdata  input  8  read data from the controller; valid in the mc_done cycle.
REQ-014 mc_done  input  1  one-cycle pulse; marks completion of the current transaction.
REQ-015 ev_valid, ev_on, ev_key[7:0]  output  1/1/8  key event: valid, 1 = note-on / 0 = note-off, key index.
REQ-016 ev_ready  input  1  consumer accepts the event when ev_valid and ev_ready are both high.

Function
REQ-017 The RAM byte per key SHALL be {4'b0, cnt[2:0], pressed}.
REQ-018 FSM states SHALL be INIT_REQ, INIT_WAIT, IDLE, RD_REQ, RD_WAIT, UPD, WR_REQ, WR_WAIT, EVT, NEXT.
REQ-019 After reset the FSM SHALL write 8'h00 to each key address 0..NUM_KEYS-1 in order (INIT_REQ then INIT_WAIT per key), then enter IDLE and drop busy.
REQ-020 mc_start SHALL pulse for exactly one cycle on entry to each *_REQ state.
REQ-021 mc_rw, mc_addr and mc_wdata SHALL be driven with that pulse and held constant until mc_done.
REQ-022 The FSM SHALL issue no new mc_start while any transaction is outstanding.
REQ-023 In IDLE, scan_go SHALL capture key_vec into a snapshot register, set key index k=0, assert busy the next cycle and go to RD_REQ.
REQ-024 scan_go SHALL be ignored when not in IDLE, including during INIT.
REQ-025 RD_WAIT SHALL latch mc_rdata on mc_done and go to UPD.
REQ-026 UPD (one cycle): let raw = snapshot[k].
- If raw == pressed: cnt becomes 0 and no event.
- Else if cnt+1 == DEBOUNCE: pressed becomes raw, cnt becomes 0, and an event is flagged with ev_on = raw.
- Else: cnt becomes cnt+1.
REQ-027 WR_REQ/WR_WAIT SHALL write the updated byte back to key k's address.
REQ-028 After the write's mc_done, the FSM SHALL go to EVT if an event is flagged, else to NEXT.
REQ-029 In EVT, ev_valid SHALL be high with ev_key=k and ev_on set.
REQ-030 ev_valid, ev_key and ev_on SHALL hold stable until ev_ready; the handshake cycle SHALL deassert ev_valid and go to NEXT.
REQ-031 NEXT: if k == NUM_KEYS-1, the FSM SHALL go to IDLE and deassert busy; else k increments and the FSM goes to RD_REQ.
REQ-032 key_vec changes during a pass SHALL NOT affect that pass.
REQ-033 At most one event SHALL be produced per key per pass.
REQ-034 Read bits 7:4 SHALL be ignored and written back as 0; cnt values >= DEBOUNCE read from RAM SHALL be treated as DEBOUNCE-1.
REQ-035 If ev_ready is already high when ev_valid rises, the event SHALL complete in one cycle.

Reset
REQ-036 Asserting reset at any time, including mid-transaction or mid-event, SHALL asynchronously force:
- the FSM to INIT_REQ with k=0;
- mc_start=0, mc_rw=0, mc_addr=0, mc_wdata=0;
- ev_valid=0, ev_on=0, ev_key=0;
- busy=1 and the snapshot register to 0.
REQ-037 After reset release the block SHALL perform the full INIT sequence before honouring scan_go.

Verification
REQ-038 NUM_KEYS=4: reset release -> four writes of 8'h00 to 0,1,2,3, then busy=0; scan_go pulsed mid-INIT is ignored.
REQ-039 DEBOUNCE=3, key 2 held pressed, three scan passes -> RAM[2] = 02, 04, then 01; note-on ev_key=2 on pass 3 only.
REQ-040 Key 1 pressed for 2 passes, then released -> no event; RAM[1] returns to 00.
REQ-041 ev_ready held low 20 cycles during an event -> ev_valid and ev_key stay stable, no mc_start issued; the pass resumes after acceptance.
REQ-042 reset pulsed while RD_WAIT is outstanding -> outputs return to reset values immediately; INIT restarts at address 0.
REQ-043 key_vec toggled mid-pass -> events match the scan_go snapshot; mc_start never asserted twice before mc_done.
